// File: rtl/key_entry_strobe_pkg.sv
// ----------------------------------------------------------------------------
// key_entry_strobe_pkg
//   Shared FSM state encoding and default debounce length for key_entry_strobe.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package key_entry_strobe_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // 10 ms of stable level at 50 MHz
  localparam int unsigned c_DEB_CYCLES_DEF = 500000;

endpackage

`default_nettype wire

// File: rtl/key_entry_strobe_sync_2ff.sv
// ----------------------------------------------------------------------------
// key_entry_strobe_sync_2ff
//   Two-flop synchroniser for asynchronous level inputs, parameterised width.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_entry_strobe_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
    end
  end

  assign dout = r_sync;

endmodule

`default_nettype wire

// File: rtl/key_entry_strobe.sv
// ----------------------------------------------------------------------------
// key_entry_strobe
//   Debounces an enter button and emits one CE_O strobe per press with the
//   switch nibble captured at acceptance; also counts presses.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_entry_strobe
  import key_entry_strobe_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = c_DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN,
  input  logic [3:0] SW,
  output logic [3:0] DAT_O,
  output logic       CE_O,
  output logic       BUSY,
  output logic [7:0] KEY_CNT
);

  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic       w_btn_s;
  logic [3:0] w_sw_s;

  state_t           r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_deb_cnt, w_deb_cnt_nxt;
  logic [3:0]       r_dat,     w_dat_nxt;
  logic             r_ce,      w_ce_nxt;
  logic [7:0]       r_key_cnt, w_key_cnt_nxt;

  key_entry_strobe_sync_2ff #(.WIDTH(1)) u_sync_btn (
    .CLK  (CLK),
    .RST  (RST),
    .din  (BTN),
    .dout (w_btn_s)
  );

  key_entry_strobe_sync_2ff #(.WIDTH(4)) u_sync_sw (
    .CLK  (CLK),
    .RST  (RST),
    .din  (SW),
    .dout (w_sw_s)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_deb_cnt <= '0;
      r_dat     <= '0;
      r_ce      <= 1'b0;
      r_key_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_cnt_nxt;
      r_dat     <= w_dat_nxt;
      r_ce      <= w_ce_nxt;
      r_key_cnt <= w_key_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_deb_cnt_nxt = r_deb_cnt;
    w_dat_nxt     = r_dat;
    w_ce_nxt      = 1'b0;
    w_key_cnt_nxt = r_key_cnt;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt   = WAIT_PRESS;
          w_deb_cnt_nxt = '0;
        end
      end
      WAIT_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          // Switch value is captured exactly once, at acceptance
          w_state_nxt   = PRESSED;
          w_dat_nxt     = w_sw_s;
          w_ce_nxt      = 1'b1;
          w_key_cnt_nxt = r_key_cnt + 8'd1;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt   = WAIT_RELEASE;
          w_deb_cnt_nxt = '0;
        end
      end
      WAIT_RELEASE: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign DAT_O   = r_dat;
  assign CE_O    = r_ce;
  assign BUSY    = (r_state != IDLE);
  assign KEY_CNT = r_key_cnt;

endmodule

`default_nettype wire

// File: tb/tb_key_entry_strobe.sv
// ----------------------------------------------------------------------------
// tb_key_entry_strobe
//   Randomised and directed stimulus for key_entry_strobe against a
//   run-length debounce reference model.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_key_entry_strobe;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       BTN = 1'b0;
  logic [3:0] SW  = 4'h0;
  logic [3:0] DAT_O;
  logic       CE_O;
  logic       BUSY;
  logic [7:0] KEY_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 2-cycle input delay, debounced level, run of opposite samples
  logic       m_b1, m_b2;
  logic [3:0] m_s1, m_s2;
  logic       m_level;
  int         m_run;
  logic [3:0] m_dat;
  logic [7:0] m_cnt;
  logic       m_ce;

  int ce_seen  = 0;
  int cyc      = 0;
  int first_ce = -1;
  int first_bs = -1;

  key_entry_strobe #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN     (BTN),
    .SW      (SW),
    .DAT_O   (DAT_O),
    .CE_O    (CE_O),
    .BUSY    (BUSY),
    .KEY_CNT (KEY_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0;
    m_level = 0; m_run = 0; m_dat = 0; m_cnt = 0; m_ce = 0;
  endtask

  task automatic model_edge();
    logic       s;
    logic [3:0] sws;
    s   = m_b2;
    sws = m_s2;
    m_b2 = m_b1; m_b1 = BTN;
    m_s2 = m_s1; m_s1 = SW;
    m_ce = 0;
    // A level change needs DEB+1 consecutive opposite samples
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_run = 0;
        m_level = s;
        if (s) begin
          m_ce  = 1;
          m_dat = sws;
          m_cnt = m_cnt + 8'd1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input logic b, input logic [3:0] sw);
    BTN = b;
    SW  = sw;
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    if (CE_O === 1'b1) begin
      ce_seen++;
      if (first_ce < 0) first_ce = cyc;
    end
    if (BUSY === 1'b1 && first_bs < 0) first_bs = cyc;
    check_val("ce",   {31'd0, CE_O}, {31'd0, m_ce});
    check_val("dat",  {28'd0, DAT_O}, {28'd0, m_dat});
    check_val("busy", {31'd0, BUSY}, {31'd0, (m_level || m_run > 0)});
    check_val("cnt",  {24'd0, KEY_CNT}, {24'd0, m_cnt});
  endtask

  task automatic reset_now(input string tag);
    RST = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_ce"},   {31'd0, CE_O}, 32'd0);
    check_val({tag, "_dat"},  {28'd0, DAT_O}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    check_val({tag, "_cnt"},  {24'd0, KEY_CNT}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    cyc = 0; first_ce = -1; first_bs = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ce0;
    int lvl;
    int len;
    bit found;
    model_reset();
    BTN = 1'b1;
    #12;
    reset_now("rst0");

    // Clean press, BTN high before edge 1
    ce0 = ce_seen;
    repeat (20) step(1'b1, 4'h7);
    check_val("clean_ce_edge",   first_ce, 32'd7);
    check_val("clean_busy_edge", first_bs, 32'd3);
    check_val("clean_dat",       {28'd0, DAT_O}, 32'h7);
    check_val("clean_cnt",       {24'd0, KEY_CNT}, 32'd1);
    check_val("clean_nce",       ce_seen - ce0, 32'd1);
    repeat (10) step(1'b0, 4'h7);
    check_val("clean_idle", {31'd0, BUSY}, 32'd0);

    // Press bounce then release bounce
    ce0 = ce_seen;
    step(1, 4'h5); step(1, 4'h5); step(0, 4'h5); step(1, 4'h5); step(0, 4'h5);
    repeat (12) step(1'b1, 4'h5);
    step(0, 4'h5); step(1, 4'h5); step(0, 4'h5); step(1, 4'h5);
    repeat (12) step(1'b0, 4'h5);
    check_val("bounce_nce", ce_seen - ce0, 32'd1);
    check_val("bounce_dat", {28'd0, DAT_O}, 32'h5);

    // Data hold while pressed, next press takes new value
    repeat (10) step(1'b1, 4'hC);
    repeat (10) step(1'b1, 4'h3);
    check_val("hold_dat", {28'd0, DAT_O}, 32'hC);
    repeat (10) step(1'b0, 4'h3);
    repeat (10) step(1'b1, 4'h3);
    check_val("next_dat", {28'd0, DAT_O}, 32'h3);
    repeat (10) step(1'b0, 4'h3);

    // Random bouncy segments with random switches
    repeat (300) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      repeat (len) step(lvl[0], 4'($urandom));
    end

    // Reset landing on the CE_O cycle, then held press gives one strobe
    repeat (10) step(1'b0, 4'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 4'h9);
      if (CE_O === 1'b1) found = 1;
    end
    check_val("ce_found", {31'd0, found}, 32'd1);
    reset_now("rst_ce");
    ce0 = ce_seen;
    repeat (25) step(1'b1, 4'hA);
    check_val("post_rst_nce", ce_seen - ce0, 32'd1);
    check_val("post_rst_dat", {28'd0, DAT_O}, 32'hA);

    // Counter wrap over 256 presses
    reset_now("rst_wrap");
    ce0 = ce_seen;
    repeat (256) begin
      repeat (6) step(1'b1, 4'($urandom));
      repeat (6) step(1'b0, 4'($urandom));
    end
    check_val("wrap_cnt", {24'd0, KEY_CNT}, 32'd0);
    check_val("wrap_nce", ce_seen - ce0, 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
